// File: rtl/led_trail_pkg.sv
// Shared constants, level type and the saturating decay helper for the
// LED afterglow trail.
package led_trail_pkg;

  localparam int NUM_LEDS_DEF     = 10;
  localparam int LEVEL_W_DEF      = 4;
  localparam int LEVEL_MAX        = (1 << LEVEL_W_DEF) - 1;
  localparam int DECAY_STEP_DEF   = 3;
  localparam int PWM_PRESCALE_DEF = 64;

  typedef logic [LEVEL_W_DEF-1:0] level_t;

  localparam level_t LEVEL_MAX_L = level_t'(LEVEL_MAX);

  // Subtract step from lvl, clamping at zero instead of wrapping around.
  function automatic level_t sat_decay(input level_t lvl, input level_t step);
    level_t res;
    if (lvl >= step) begin
      res = level_t'(lvl - step);
    end else begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_trail_channel.sv
// One LED channel: brightness level register with load/decay on each
// qualifying step, and a registered PWM comparator driving the LED.
module led_trail_channel
  import led_trail_pkg::*;
#(
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic   CLOCK_50,
  input  logic   RESET_N,
  input  logic   upd,
  input  logic   sel,
  input  level_t pwm_cnt,
  output logic   led,
  output logic   level_nz
);

  level_t level_q, level_d;
  logic   led_q, led_d;

  // Next level: load full brightness when selected, otherwise fade; hold
  // between updates. PWM drive compares the current level to the counter.
  always_comb begin
    level_d = level_q;
    if (upd) begin
      if (sel) begin
        level_d = LEVEL_MAX_L;
      end else begin
        level_d = sat_decay(level_q, level_t'(DECAY_STEP));
      end
    end
    led_d = (level_q == LEVEL_MAX_L) | (level_q > pwm_cnt);
  end

  // Level and LED output registers, cleared asynchronously.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led      = led_q;
  assign level_nz = |level_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Afterglow trail stage behind the KITT scanner: latches the scanner
// position on each step, fades previously lit LEDs and PWM-modulates LEDR
// against a shared, prescaled PWM counter.
module led_trail_pwm
  import led_trail_pkg::*;
#(
  parameter int NUM_LEDS     = NUM_LEDS_DEF,
  parameter int LEVEL_W      = LEVEL_W_DEF,
  parameter int DECAY_STEP   = DECAY_STEP_DEF,
  parameter int PWM_PRESCALE = PWM_PRESCALE_DEF
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                step_tick,
  input  logic                hold,
  input  logic [NUM_LEDS-1:0] pos_onehot,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                trail_active
);

  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  // The level type lives in the package; a differing width cannot be honoured.
  if (LEVEL_W != LEVEL_W_DEF) begin : g_bad_level_w
    $error("led_trail_pwm: LEVEL_W must equal led_trail_pkg::LEVEL_W_DEF");
  end

  logic [PS_W-1:0]     presc_q, presc_d;
  level_t              pwm_q, pwm_d;
  logic                trail_q, trail_d;
  logic                presc_wrap;
  logic                upd;
  logic [NUM_LEDS-1:0] led_vec;
  logic [NUM_LEDS-1:0] nz_vec;

  // A step only counts when the scanner is not frozen.
  assign upd = step_tick & ~hold;

  // Prescaler wraps every PWM_PRESCALE clocks and advances the PWM counter,
  // which rolls over naturally from LEVEL_MAX to 0.
  always_comb begin
    presc_wrap = (presc_q == PS_W'(PWM_PRESCALE - 1));
    presc_d    = presc_wrap ? '0 : PS_W'(presc_q + 1'b1);
    pwm_d      = presc_wrap ? level_t'(pwm_q + 1'b1) : pwm_q;
    trail_d    = |nz_vec;
  end

  // Prescaler, PWM counter and trail-active registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      pwm_q   <= '0;
      trail_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      trail_q <= trail_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_trail_channel #(
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .upd      (upd),
      .sel      (pos_onehot[i]),
      .pwm_cnt  (pwm_q),
      .led      (led_vec[i]),
      .level_nz (nz_vec[i])
    );
  end

  assign LEDR         = led_vec;
  assign trail_active = trail_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: reset, single hit, decay to zero,
// duty measurement, hold, mid-trail reset and a full scan sweep. Brightness
// is observed as the count of LEDR high cycles over one 1024-clock frame.
module tb_led_trail_pwm;

  localparam int N     = 10;
  localparam int FRAME = 1024;

  logic         clk;
  logic         rst_n;
  logic         step_tick;
  logic         hold;
  logic [N-1:0] pos_onehot;
  logic [N-1:0] ledr;
  logic         trail_active;

  int n_checks;
  int n_fail;
  int duty_cnt [N];
  int exp_lvl  [N];
  logic [15:0] exp_q [$];

  led_trail_pwm dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .step_tick    (step_tick),
    .hold         (hold),
    .pos_onehot   (pos_onehot),
    .LEDR         (ledr),
    .trail_active (trail_active)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Checking task
  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected high cycles per frame for a level
  function automatic int duty_of(input int lvl);
    return (lvl == 15) ? FRAME : lvl * 64;
  endfunction

  // Driver: one step_tick with the given position; returns in cycle T+1.
  // Between ticks pos_onehot carries junk, which must be ignored.
  task automatic do_tick(input logic [N-1:0] pos);
    @(posedge clk);
    #1;
    pos_onehot = pos;
    step_tick  = 1'b1;
    @(posedge clk);
    #1;
    step_tick  = 1'b0;
    pos_onehot = N'($urandom_range(0, 1023));
  endtask

  task automatic set_exp(input int l9, input int l8, input int l7, input int l6,
                         input int l5, input int l4, input int l3, input int l2,
                         input int l1, input int l0);
    exp_lvl[9] = l9; exp_lvl[8] = l8; exp_lvl[7] = l7; exp_lvl[6] = l6;
    exp_lvl[5] = l5; exp_lvl[4] = l4; exp_lvl[3] = l3; exp_lvl[2] = l2;
    exp_lvl[1] = l1; exp_lvl[0] = l0;
  endtask

  // Scoreboard: measure one frame of LEDR and compare against exp_lvl
  task automatic check_frame(input string tag);
    bit any_nz;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) duty_cnt[i] = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) duty_cnt[i] += int'(ledr[i]);
    end
    any_nz = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(16'(duty_of(exp_lvl[i])));
      if (exp_lvl[i] != 0) any_nz = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_duty_led%0d", tag, i), duty_cnt[i], int'(exp_q.pop_front()));
    end
    check_eq($sformatf("%s_trail_active", tag), int'(trail_active), int'(any_nz));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    step_tick  = 1'b0;
    hold       = 1'b0;
    pos_onehot = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_ledr", int'(ledr), 0);
    check_eq("reset_trail", int'(trail_active), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single hit: latency, then LED0 on for a whole frame
    do_tick(N'(1));
    @(negedge clk);
    check_eq("hit_latency_led0", int'(ledr[0]), 0);
    check_eq("hit_latency_trail", int'(trail_active), 0);
    set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 15);
    check_frame("hit");

    // Decay 15 -> 12, 9, 6, 3, 0, 0 with saturation at zero
    for (int k = 1; k <= 6; k++) begin
      int lvl;
      lvl = 15 - 3 * k;
      if (lvl < 0) lvl = 0;
      do_tick('0);
      if (k == 5) begin
        @(negedge clk);
        check_eq("decay_trail_t1", int'(trail_active), 1);
        @(negedge clk);
        check_eq("decay_trail_t2", int'(trail_active), 0);
      end
      set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, lvl);
      check_frame($sformatf("decay%0d", k));
    end

    // Duty: LED3 at level 6 gives 384 high cycles
    do_tick(N'(1 << 3));
    repeat (3) do_tick('0);
    set_exp(0, 0, 0, 0, 0, 0, 6, 0, 0, 0);
    check_frame("duty6");

    // Hold: ticks ignored, levels and duty unchanged
    hold = 1'b1;
    do_tick(N'(1 << 5));
    do_tick('0);
    do_tick(N'(10'h3FF));
    do_tick(N'(1 << 3));
    do_tick(N'(1 << 7));
    hold = 1'b0;
    check_frame("hold");

    // Reset mid-trail: outputs clear before the next clock edge
    do_tick(N'(1 << 3));
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_reset_led3", int'(ledr[3]), 1);
    rst_n = 1'b0;
    #2;
    check_eq("async_reset_ledr", int'(ledr), 0);
    check_eq("async_reset_trail", int'(trail_active), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_frame("post_reset");

    // Scan sweep LED0..LED9
    for (int k = 0; k < N; k++) do_tick(N'(1 << k));
    set_exp(15, 12, 9, 6, 3, 0, 0, 0, 0, 0);
    check_frame("sweep");

    // Non-one-hot position loads both ends
    do_tick(N'(10'b1000000001));
    set_exp(15, 9, 6, 3, 0, 0, 0, 0, 0, 15);
    check_frame("two_hot");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
